// File: rtl/chroni_vram_arbiter.sv
// Two-requester read arbiter for the chroni-side VRAM port B: display fetcher vs aux engine.
// One read issued per sys_clk; data returns to the originating requester RD_LATENCY+1 edges after accept.
module chroni_vram_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 8,
  parameter int RD_LATENCY   = 2,
  parameter int AUX_MAX_WAIT = 15
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              disp_priority,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              aux_req,
  input  logic [ADDR_W-1:0] aux_addr,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] aux_rdata,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic [DATA_W-1:0] vram_rd_data,
  output logic              busy
);

  localparam int DEPTH = RD_LATENCY + 1;
  localparam logic [3:0] WAIT_MAX = 4'(AUX_MAX_WAIT);

  logic [DEPTH-1:0] tag_valid;
  logic [DEPTH-1:0] tag_aux;
  logic [3:0]       aux_wait;
  logic             last_grant_aux;
  logic             accept;
  logic             ret_disp;
  logic             ret_aux;

  // Forced aux grant beats display priority once aux has waited long enough.
  always_comb begin
    disp_gnt = 1'b0;
    aux_gnt  = 1'b0;
    if (reset_n) begin
      if (disp_req && aux_req) begin
        if (aux_wait == WAIT_MAX) begin
          aux_gnt = 1'b1;
        end else if (disp_priority) begin
          disp_gnt = 1'b1;
        end else if (last_grant_aux) begin
          disp_gnt = 1'b1;
        end else begin
          aux_gnt = 1'b1;
        end
      end else if (disp_req) begin
        disp_gnt = 1'b1;
      end else if (aux_req) begin
        aux_gnt = 1'b1;
      end
    end
  end

  assign accept   = disp_gnt | aux_gnt;
  assign ret_disp = tag_valid[DEPTH-1] & ~tag_aux[DEPTH-1];
  assign ret_aux  = tag_valid[DEPTH-1] &  tag_aux[DEPTH-1];
  assign busy     = |tag_valid;

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      vram_addr      <= '0;
      tag_valid      <= '0;
      tag_aux        <= '0;
      aux_wait       <= 4'd0;
      last_grant_aux <= 1'b1;
      disp_rvalid    <= 1'b0;
      aux_rvalid     <= 1'b0;
      disp_rdata     <= '0;
      aux_rdata      <= '0;
    end else begin
      if (accept) begin
        vram_addr      <= aux_gnt ? aux_addr : disp_addr;
        last_grant_aux <= aux_gnt;
      end
      tag_valid <= {tag_valid[DEPTH-2:0], accept};
      tag_aux   <= {tag_aux[DEPTH-2:0], aux_gnt};

      disp_rvalid <= ret_disp;
      aux_rvalid  <= ret_aux;
      if (ret_disp) disp_rdata <= vram_rd_data;
      if (ret_aux)  aux_rdata  <= vram_rd_data;

      if (!aux_req || aux_gnt) begin
        aux_wait <= 4'd0;
      end else if (aux_wait != WAIT_MAX) begin
        aux_wait <= aux_wait + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_chroni_vram_arbiter.sv
// Bench for chroni_vram_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (grant rules + queue of reads due back at a given edge).
module tb_chroni_vram_arbiter;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;
  localparam int L      = 2;
  localparam int MAXW   = 15;

  logic              sys_clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              disp_priority = 1'b0;
  logic              disp_req = 1'b0;
  logic [ADDR_W-1:0] disp_addr = '0;
  logic              aux_req = 1'b0;
  logic [ADDR_W-1:0] aux_addr = '0;
  logic              disp_gnt, disp_rvalid, aux_gnt, aux_rvalid, busy;
  logic [DATA_W-1:0] disp_rdata, aux_rdata, vram_rd_data;
  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] ram_pipe [L];

  always #5 sys_clk = ~sys_clk;

  chroni_vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(L), .AUX_MAX_WAIT(MAXW)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .disp_priority(disp_priority),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .aux_req(aux_req), .aux_addr(aux_addr), .aux_gnt(aux_gnt),
    .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
    .vram_addr(vram_addr), .vram_rd_data(vram_rd_data), .busy(busy));

  function automatic logic [7:0] mem(input logic [16:0] a);
    logic [7:0] r;
    r = a[7:0] * 8'd29;
    r = r ^ a[15:8] ^ {7'd0, a[16]};
    return r;
  endfunction

  // VRAM port B: data for an address is valid L edges after the address changes.
  always @(posedge sys_clk) begin
    ram_pipe[0] <= mem(vram_addr);
    for (int i = 1; i < L; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign vram_rd_data = ram_pipe[L-1];

  typedef struct {
    int          due;
    bit          is_aux;
    logic [16:0] addr;
  } ent_t;

  ent_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          m_wait = 0;
  bit          m_last_aux = 1'b1;
  logic [16:0] e_vaddr = '0;
  logic [7:0]  e_drd = '0, e_ard = '0;
  bit          e_dv = 1'b0, e_av = 1'b0;
  bit          eg_d, eg_a, g_d, g_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // One sys_clk cycle: inputs are already driven (just after a negedge).
  task automatic step();
    ent_t e;
    #1;
    eg_d = 1'b0;
    eg_a = 1'b0;
    if (reset_n) begin
      if (disp_req && aux_req) begin
        if (m_wait == MAXW) eg_a = 1'b1;
        else if (disp_priority) eg_d = 1'b1;
        else if (m_last_aux) eg_d = 1'b1;
        else eg_a = 1'b1;
      end else begin
        eg_d = disp_req;
        eg_a = aux_req;
      end
    end
    g_d = disp_gnt;
    g_a = aux_gnt;
    check("disp_gnt", 32'(g_d), 32'(eg_d));
    check("aux_gnt", 32'(g_a), 32'(eg_a));
    @(posedge sys_clk);
    if (!reset_n) begin
      q.delete();
      m_wait = 0;
      m_last_aux = 1'b1;
      e_vaddr = '0;
      e_drd = '0;
      e_ard = '0;
      e_dv = 1'b0;
      e_av = 1'b0;
    end else begin
      e_dv = 1'b0;
      e_av = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        if (e.is_aux) begin e_av = 1'b1; e_ard = mem(e.addr); end
        else begin e_dv = 1'b1; e_drd = mem(e.addr); end
      end
      if (eg_d || eg_a) begin
        e.due = cyc + L + 1;
        e.is_aux = eg_a;
        e.addr = eg_a ? aux_addr : disp_addr;
        q.push_back(e);
        e_vaddr = e.addr;
        m_last_aux = eg_a;
      end
      if (!aux_req || eg_a) m_wait = 0;
      else if (m_wait < MAXW) m_wait++;
    end
    cyc++;
    #1;
    check("vram_addr", 32'(vram_addr), 32'(e_vaddr));
    check("disp_rvalid", 32'(disp_rvalid), 32'(e_dv));
    check("aux_rvalid", 32'(aux_rvalid), 32'(e_av));
    check("disp_rdata", 32'(disp_rdata), 32'(e_drd));
    check("aux_rdata", 32'(aux_rdata), 32'(e_ard));
    check("busy", 32'(busy), 32'(q.size() > 0));
    @(negedge sys_clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    disp_req = 1'b0;
    aux_req = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    int n;
    @(negedge sys_clk);
    do_reset();
    check("reset_vram_addr", 32'(vram_addr), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);

    // single display read
    disp_req = 1'b1;
    disp_addr = 17'h00123;
    step();
    check("single_gnt", 32'(g_d), 32'h1);
    check("single_vaddr", 32'(vram_addr), 32'h00123);
    disp_req = 1'b0;
    step();
    step();
    check("single_early", 32'(disp_rvalid), 32'h0);
    step();
    check("single_rvalid", 32'(disp_rvalid), 32'h1);
    check("single_aux_rvalid", 32'(aux_rvalid), 32'h0);
    step();

    // round-robin
    do_reset();
    disp_priority = 1'b0;
    disp_req = 1'b1; disp_addr = 17'h00010;
    aux_req = 1'b1; aux_addr = 17'h00020;
    for (int i = 0; i < 8; i++) begin
      step();
      check("rr_disp", 32'(g_d), 32'(i % 2 == 0));
    end
    disp_req = 1'b0; aux_req = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // starvation guard + aux hold at 0x1FFFF
    do_reset();
    disp_priority = 1'b1;
    disp_req = 1'b1; disp_addr = 17'h00777;
    aux_req = 1'b1; aux_addr = 17'h1FFFF;
    for (int i = 0; i < 32; i++) begin
      step();
      check("starve_aux", 32'(g_a), 32'(i % 16 == 15));
      if (i == 15) check("starve_vaddr", 32'(vram_addr), 32'h1FFFF);
    end
    disp_req = 1'b0; aux_req = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // display burst 0..79
    do_reset();
    n = 0;
    disp_req = 1'b1;
    for (int i = 0; i < 80; i++) begin
      disp_addr = 17'(i);
      step();
      if (disp_rvalid) n++;
      check("burst_gnt", 32'(g_d), 32'h1);
    end
    disp_req = 1'b0;
    begin
      int k;
      k = 0;
      for (int i = 0; i < 10; i++) begin
        if (busy || i == 0) begin
          step();
          k++;
          if (disp_rvalid) n++;
        end
      end
      check("burst_busy_fall", 32'(k), 32'd3);
    end
    check("burst_rvalid_count", 32'(n), 32'd80);

    // reset mid-flight
    do_reset();
    disp_req = 1'b1; disp_addr = 17'h00055; step();
    disp_addr = 17'h00056; step();
    disp_req = 1'b0; step();
    n = 0;
    reset_n = 1'b0; step();
    reset_n = 1'b1;
    check("midrst_vaddr", 32'(vram_addr), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      if (disp_rvalid || aux_rvalid) n++;
    end
    check("midrst_no_rvalid", 32'(n), 32'h0);

    // randomized traffic honouring the hold-until-grant rule
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (!disp_req || eg_d) begin
        disp_req = ($urandom_range(0, 3) != 0);
        disp_addr = 17'($urandom);
      end
      if (!aux_req || eg_a) begin
        aux_req = ($urandom_range(0, 2) != 0);
        aux_addr = 17'($urandom);
      end
      if ($urandom_range(0, 19) == 0) disp_priority = ~disp_priority;
      reset_n = ($urandom_range(0, 249) != 0);
      step();
    end
    reset_n = 1'b1;
    disp_req = 1'b0; aux_req = 1'b0;
    for (int i = 0; i < 5; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
